// File: rtl/s1_seq.sv
// Registered 4:1 mux cell: select bits gated from A0 and A1&B1, then a D flip-flop with async clear.
// Latency: one clk; the mux value at rising edge N appears on out after edge N and holds until N+1.
// No backpressure: the cell captures on every rising edge while clr is high.
module s1_seq (
    input  logic [3:0] d,
    input  logic       A0,
    input  logic       B1,
    input  logic       A1,
    input  logic       clr,
    input  logic       clk,
    output logic       out
);

    logic       s1;
    logic       s0;
    logic [1:0] sel;
    logic       m;

    // Select generation and data mux; an X on a select yields an X mux value with no masking.
    always_comb begin
        s1  = A1 & B1;
        s0  = A0;
        sel = {s1, s0};
        m   = d[sel];
    end

    // Capture flop; clr low clears out immediately and overrides a coincident clock edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            out <= 1'b0;
        end else begin
            out <= m;
        end
    end

endmodule

// File: tb/tb_s1_seq.sv
module tb_s1_seq;

    logic [3:0] d;
    logic       A0;
    logic       B1;
    logic       A1;
    logic       clr;
    logic       clk;
    logic       out;

    int total = 0;
    int bad   = 0;

    s1_seq dut (
        .d   (d),
        .A0  (A0),
        .B1  (B1),
        .A1  (A1),
        .clr (clr),
        .clk (clk),
        .out (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply a new input set on the falling edge.
    task automatic drive(input logic [3:0] dv, input logic a1, input logic b1, input logic a0);
        @(negedge clk);
        d  = dv;
        A1 = a1;
        B1 = b1;
        A0 = a0;
    endtask

    // Advance to just after the next rising edge.
    task automatic edge_then_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held low with inputs that would otherwise select d[3].
        d = 4'b0110; A1 = 1'b1; B1 = 1'b1; A0 = 1'b1; clr = 1'b0;
        #1;
        chk("reset_t0", out, 1'b0);
        edge_then_sample();
        chk("reset_edge1", out, 1'b0);
        edge_then_sample();
        chk("reset_edge2", out, 1'b0);

        // Release clear and capture d[3]=0 twice.
        @(negedge clk);
        clr = 1'b1;
        edge_then_sample();
        chk("cap_d3_c1", out, 1'b0);
        edge_then_sample();
        chk("cap_d3_c2", out, 1'b0);

        // Select map with d=0110: d0=0, d1=1, d2=1, d3=0.
        drive(4'b0110, 1'b0, 1'b0, 1'b0);
        edge_then_sample();
        chk("sel_00", out, 1'b0);
        drive(4'b0110, 1'b0, 1'b0, 1'b1);
        edge_then_sample();
        chk("sel_01", out, 1'b1);
        drive(4'b0110, 1'b1, 1'b1, 1'b0);
        edge_then_sample();
        chk("sel_10", out, 1'b1);
        drive(4'b0110, 1'b1, 1'b1, 1'b1);
        edge_then_sample();
        chk("sel_11", out, 1'b0);
        drive(4'b0110, 1'b1, 1'b0, 1'b1);
        edge_then_sample();
        chk("sel_a1_only", out, 1'b1);
        drive(4'b0110, 1'b0, 1'b1, 1'b0);
        edge_then_sample();
        chk("sel_b1_only", out, 1'b0);
        drive(4'b1001, 1'b0, 1'b1, 1'b1);
        edge_then_sample();
        chk("sel_b1_a0_d1001", out, 1'b0);
        drive(4'b1001, 1'b1, 1'b1, 1'b1);
        edge_then_sample();
        chk("sel_11_d1001", out, 1'b1);

        // Load a 1 then drop clear between edges.
        drive(4'b0110, 1'b0, 1'b0, 1'b1);
        edge_then_sample();
        chk("async_preload", out, 1'b1);
        @(negedge clk);
        #1;
        clr = 1'b0;
        #1;
        chk("async_clear_now", out, 1'b0);

        // Release with S=01, d[1]=1: out stays 0 until the first rising edge.
        #1;
        clr = 1'b1;
        #1;
        chk("release_before_edge", out, 1'b0);
        edge_then_sample();
        chk("release_first_edge", out, 1'b1);

        // Inputs change while clk is low; out must hold until the next edge.
        drive(4'b0000, 1'b1, 1'b1, 1'b0);
        #2;
        chk("hold_low_a", out, 1'b1);
        edge_then_sample();
        chk("hold_capture_a", out, 1'b0);
        drive(4'b1111, 1'b0, 1'b0, 1'b0);
        #3;
        chk("hold_low_b", out, 1'b0);
        edge_then_sample();
        chk("hold_capture_b", out, 1'b1);

        // Clear dropping on a rising edge while the mux presents 1: clear wins.
        @(posedge clk);
        clr = 1'b0;
        #1;
        chk("clear_vs_edge", out, 1'b0);
        edge_then_sample();
        chk("clear_held_edge", out, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
